uart_rx_byte: RTL and testbench

Serial-to-parallel UART receiver (8N1) that sits directly upstream of the UART command FSM. It oversamples the asynchronous `uart_rx` line on `sysclk` and delivers each received byte on `uart_datain`. Completion is signalled by a single-cycle `dataAvailable` strobe, which drives the FSM's identically named inputs without glue logic. Framing errors are flagged and the corrupt byte is dropped, so the FSM never sees it.

---
 rtl/uart_rx_byte.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: oversamples uart_rx on sysclk and emits each good byte with a one-cycle dataAvailable strobe.
// Optional macro UART_RX_MAJORITY_EN: take every line sample as the 2-of-3 majority of the synchronized history.
module uart_rx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       uart_rx,
   output logic [7:0] uart_datain,
   output logic       dataAvailable,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam logic [15:0] HALF_M1 = 16'((CLKS_PER_BIT / 2) - 1);
   localparam logic [15:0] BIT_M1  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q;
   logic        rx_s_q;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bidx_q, bidx_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [7:0]  data_q, data_d;
   logic        da_q, da_d;
   logic        fe_q, fe_d;
   logic        busy_q, busy_d;
   logic        samp;

   // Line sample used at the start, data and stop decision points.
`ifdef UART_RX_MAJORITY_EN
   logic [2:0] rx_h_q;

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         rx_h_q <= 3'b111;
      end else begin
         rx_h_q <= {rx_h_q[1:0], rx_s_q};
      end
   end

   always_comb begin
      samp = (rx_h_q[0] & rx_h_q[1]) | (rx_h_q[0] & rx_h_q[2]) | (rx_h_q[1] & rx_h_q[2]);
   end
`else
   always_comb begin
      samp = rx_s_q;
   end
`endif

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         sync1_q <= uart_rx;
         rx_s_q  <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      da_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 16'd0;
            if (!rx_s_q) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = 16'd0;
               if (!samp) begin
                  state_d = DATA;
                  bidx_d  = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = 16'd0;
               shreg_d = {samp, shreg_q[7:1]};
               if (bidx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = 16'd0;
               if (samp) begin
                  data_d  = shreg_q;
                  da_d    = 1'b1;
                  state_d = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = BRK;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         BRK: begin
            // A held-low line must go high before a new start bit is accepted.
            cnt_d = 16'd0;
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 16'd0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         bidx_q  <= 3'd0;
         shreg_q <= 8'h00;
         data_q  <= 8'h00;
         da_q    <= 1'b0;
         fe_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         da_q    <= da_d;
         fe_q    <= fe_d;
         busy_q  <= busy_d;
      end
   end

   assign uart_datain   = data_q;
   assign dataAvailable = da_q;
   assign frame_error   = fe_q;
   assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte at CLKS_PER_BIT=16: frame-level driver, expected-event queue, monitor and summary.
module tb_uart_rx_byte;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT  = 3 + HALF + 9 * CPB;

   logic       sysclk = 1'b0;
   logic       reset;
   logic       uart_rx;
   logic [7:0] uart_datain;
   logic       dataAvailable;
   logic       frame_error;
   logic       rx_busy;

   int          tot = 0;
   int          bad = 0;
   int unsigned cyc = 0;
   int          da_cnt = 0;
   int          fe_cnt = 0;
   logic        busy_seen;
   logic [7:0]  model_data = 8'h00;
   // Each entry: {is_frame_error, expected uart_datain, expected strobe cycle}.
   logic [40:0] exp_q[$];
   int unsigned da_times[$];

   uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
      .sysclk        (sysclk),
      .reset         (reset),
      .uart_rx       (uart_rx),
      .uart_datain   (uart_datain),
      .dataAvailable (dataAvailable),
      .frame_error   (frame_error),
      .rx_busy       (rx_busy)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string name, input int unsigned act, input int unsigned lo, input int unsigned hi);
      tot++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic monitor();
      logic [40:0] e;
      forever begin
         @(negedge sysclk);
         if (dataAvailable || frame_error) begin
            chk("strobes_exclusive", {31'd0, dataAvailable & frame_error}, 32'd0);
            if (dataAvailable) begin
               da_cnt++;
               da_times.push_back(cyc);
            end
            if (frame_error) fe_cnt++;
            if (exp_q.size() == 0) begin
               tot++;
               bad++;
               $display("FAIL unexpected_strobe actual da=%0b fe=%0b data=%0h expected none", dataAvailable, frame_error, uart_datain);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_kind", {31'd0, frame_error}, {31'd0, e[40]});
               chk("strobe_data", {24'd0, uart_datain}, {24'd0, e[39:32]});
               chk_rng("strobe_latency", cyc, e[31:0] - 1, e[31:0] + 1);
               chk("busy_at_strobe", {31'd0, rx_busy}, {31'd0, e[40]});
            end
         end
      end
   endtask

   // Drive the line to v for n cycles, noting whether rx_busy was ever seen high.
   task automatic drive_watch(input logic v, input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge sysclk);
         #1;
         uart_rx = v;
         reset   = 1'b1;
         @(negedge sysclk);
         if (rx_busy) busy_seen = 1'b1;
      end
   endtask

   // One 8N1 frame; glitch_idx inverts one line cycle, abort_idx pulls reset low for one cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_idx,
                             input int abort_idx, input logic [7:0] exp_byte);
      logic [9:0]  bits;
      int          idx;
      int unsigned t0;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < CPB; c++) begin
            @(posedge sysclk);
            #1;
            idx     = i * CPB + c;
            uart_rx = (idx == glitch_idx) ? ~bits[i] : bits[i];
            reset   = (idx == abort_idx) ? 1'b0 : 1'b1;
            if (idx == abort_idx) model_data = 8'h00;
            if (idx == 0) begin
               t0 = cyc + 1;
               if (abort_idx < 0) begin
                  if (stop) begin
                     model_data = exp_byte;
                     exp_q.push_back({1'b0, exp_byte, t0 + LAT});
                  end else begin
                     exp_q.push_back({1'b1, model_data, t0 + LAT});
                  end
               end
            end
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(negedge sysclk);
         k++;
      end
      chk("drain_empty", exp_q.size(), 32'd0);
      drive_watch(1'b1, 6);
   endtask

   initial begin
      int          da0;
      int          fe0;
      logic [7:0]  b;
      logic        stop;
      int          gap;
      logic [7:0]  glitch_exp;

      reset   = 1'b0;
      uart_rx = 1'b1;
      fork
         monitor();
      join_none
      repeat (3) @(posedge sysclk);
      #1;
      reset = 1'b1;
      @(negedge sysclk);
      chk("reset_datain", {24'd0, uart_datain}, 32'd0);
      chk("reset_da", {31'd0, dataAvailable}, 32'd0);
      chk("reset_fe", {31'd0, frame_error}, 32'd0);
      chk("reset_busy", {31'd0, rx_busy}, 32'd0);
      drive_watch(1'b1, 4);

      // Single byte
      da0 = da_cnt;
      fe0 = fe_cnt;
      send_frame(8'hA5, 1'b1, -1, -1, 8'hA5);
      drain();
      chk("single_da_count", da_cnt - da0, 32'd1);
      chk("single_fe_count", fe_cnt - fe0, 32'd0);
      chk("single_data", {24'd0, uart_datain}, 32'hA5);

      // Start glitch
      da0 = da_cnt;
      fe0 = fe_cnt;
      busy_seen = 1'b0;
      drive_watch(1'b0, 4);
      drive_watch(1'b1, 24);
      chk("glitch_busy_pulsed", {31'd0, busy_seen}, 32'd1);
      chk("glitch_busy_idle", {31'd0, rx_busy}, 32'd0);
      chk("glitch_no_strobe", (da_cnt - da0) + (fe_cnt - fe0), 32'd0);
      chk("glitch_data_kept", {24'd0, uart_datain}, 32'hA5);

      // Framing error followed by a break
      fe0 = fe_cnt;
      send_frame(8'hA5, 1'b1, -1, -1, 8'hA5);
      send_frame(8'h3C, 1'b0, -1, -1, 8'h3C);
      drive_watch(1'b0, 40);
      chk("break_busy_high", {31'd0, rx_busy}, 32'd1);
      drive_watch(1'b1, 4);
      chk("break_busy_released", {31'd0, rx_busy}, 32'd0);
      drain();
      chk("ferr_count", fe_cnt - fe0, 32'd1);
      chk("ferr_data_kept", {24'd0, uart_datain}, 32'hA5);

      // Back-to-back
      da_times.delete();
      send_frame(8'h01, 1'b1, -1, -1, 8'h01);
      send_frame(8'h02, 1'b1, -1, -1, 8'h02);
      send_frame(8'h03, 1'b1, -1, -1, 8'h03);
      drain();
      chk("b2b_count", da_times.size(), 32'd3);
      if (da_times.size() == 3) begin
         chk("b2b_gap1", da_times[1] - da_times[0], 32'd160);
         chk("b2b_gap2", da_times[2] - da_times[1], 32'd160);
      end

      // Reset during data bit 4, then a clean frame
      da0 = da_cnt;
      send_frame(8'hFF, 1'b1, -1, 5 * CPB + 4, 8'hFF);
      chk("abort_datain_cleared", {24'd0, uart_datain}, 32'd0);
      send_frame(8'h55, 1'b1, -1, -1, 8'h55);
      drain();
      chk("abort_da_count", da_cnt - da0, 32'd1);
      chk("abort_next_data", {24'd0, uart_datain}, 32'h55);

      // One-cycle inverted glitch at the data bit 3 centre
`ifdef UART_RX_MAJORITY_EN
      glitch_exp = 8'h00;
`else
      glitch_exp = 8'h08;
`endif
      send_frame(8'h00, 1'b1, 4 * CPB + HALF, -1, glitch_exp);
      drain();
      chk("glitch_bit3_data", {24'd0, uart_datain}, {24'd0, glitch_exp});

      // Randomized frames with occasional framing errors
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop, -1, -1, b);
         gap = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
         if (gap > 0) drive_watch(1'b1, gap);
      end
      drain();
      chk("random_final_data", {24'd0, uart_datain}, {24'd0, model_data});

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
